vid_capture_fifo: RTL and testbench
===================================

# vid_capture_fifo

Video capture stage feeding the pixel-read peripheral. Samples the active-pixel stream from the video source, one frame per arm request, and buffers pixels in a first-word-fall-through FIFO. The downstream reader pops pixels at its own pace and sees R/G/B plus a start-of-frame tag. Overflow is flagged rather than stalling the source, because the source cannot be back-pressured.

## Interface
- `DEPTH`, 512: FIFO depth in pixels; must be a power of two.
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `clk` in 1: clock; the video source is synchronous to it.
- `reset` in 1: reset, synchronous, active-high.
- `in_r`, `in_g`, `in_b` in 8 each: source pixel colour.
- `in_de` in 1: source data-enable; high means active pixel.
- `in_vsync` in 1: source vertical sync, active-low.
- `arm` in 1: single-cycle request to capture the next frame.
- `flush` in 1: empties the FIFO and aborts the capture.
- `pop` in 1: downstream consumes the head pixel.
- `out_r`, `out_g`, `out_b` out 8 each: head pixel colour.
- `out_sof` out 1: head pixel is the first pixel of its frame.
- `out_valid` out 1: FIFO not empty.
- `level` out $clog2(DEPTH)+1: number of entries in the FIFO.
- `capturing` out 1: state is CAPTURE.
- `frame_done` out 1: state is DONE.
- `overflow` out 1: sticky; at least one pixel was dropped.

## Operation
- **Input register.** `in_*` are registered once (stage S1); the FSM and FIFO use S1 values.
- **Frame-start event (`vs_fall`).** S1 vsync is 0 and the previous S1 vsync was 1.
- **States.** IDLE, WAIT_VS, CAPTURE, DONE.
  - IDLE: `arm` moves to WAIT_VS.
  - WAIT_VS: `vs_fall` moves to CAPTURE; clears `pix_cnt` and sets `first`.
  - CAPTURE: each S1 pixel with `de=1` is pushed as {sof=`first`, r, g, b}. `first` is then cleared and `pix_cnt` increments.
  - CAPTURE exits to DONE when `pix_cnt` reaches H_ACTIVE*V_ACTIVE. It also exits to DONE on a `vs_fall` that arrives early; that `vs_fall` does not start a new capture.
  - DONE: `arm` clears `overflow` and moves to WAIT_VS.
  - `arm` is ignored in WAIT_VS and CAPTURE.
- **Counter width.** `pix_cnt` is $clog2(H_ACTIVE*V_ACTIVE+1) bits and never wraps.
- **Dropped pixels.** A pixel counts toward `pix_cnt` even when it is dropped.
- **FIFO.** First-word-fall-through, with `DEPTH` entries of 25 bits.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`.
- **Push when full, no pop.** The pixel is dropped and `overflow` is set.
- **Push and pop when full.** Both are accepted and `level` is unchanged.
- **Push and pop when empty.** Only the push takes effect; the pop is ignored.
- **Pop when empty.** Ignored; no underflow.
- **Flush.** Pointers and `level` go to 0 and the state goes to IDLE. `overflow` is cleared. Flush takes priority over `arm`, push and pop in the same cycle.
- **Outputs while empty.** `out_r/g/b/sof` hold the last value and are don't-care while `out_valid`=0.

## Timing
- **Reset values.** The cycle after `reset` is sampled:
  - state IDLE, pointers 0, `level` 0;
  - `out_valid`, `out_sof`, `capturing`, `frame_done`, `overflow` all 0;
  - `out_r/g/b` 0;
  - the S1 register is cleared, with vsync reset to 1.
- **Reset mid-operation.** Same as above; no state or data survives.
- **Latency.** A pixel on `in_*` at edge n is in S1 at n+1 and written at n+2. At n+2, if the FIFO was empty, `out_valid`=1 and `out_*` show the pixel.
- **Pop.** `pop` sampled at edge k with `out_valid`=1 presents the next entry, or drops `out_valid`, after edge k.
- **Level.** `level` updates on the same edge as the push/pop it reflects.
- **Arm to WAIT_VS.** `arm` at edge k gives state WAIT_VS after k.
- **Frame start.** A vsync fall at the input at edge n gives `capturing`=1 after n+2. The first `de` pixel captured must arrive at the input no earlier than n+1.
- **Frame end.** The final pixel push and `frame_done`=1 occur on the same edge.
- **Throughput.** One push and one pop per cycle, sustained.

## Test plan
- **Basic frame.** Params `H_ACTIVE`=4, `V_ACTIVE`=2, `DEPTH`=16. Arm, then send a vsync pulse and 8 `de` pixels of value i*0x010101, with `pop` held low. Expect `level`=8, `frame_done`=1, first entry `sof`=1 with rgb 000000, the others `sof`=0, `overflow`=0. Popping yields 0x000000..0x070707 in order.
- **Overflow.** `DEPTH`=4, same frame, no pops. Expect `level`=4 and `overflow`=1; the entries are pixels 0..3. After `arm` in DONE, `overflow`=0.
- **Full with simultaneous push/pop.** FIFO full, push and pop on the same cycle. Expect `level` stays 4, `overflow` stays 0, and the head advances by one.
- **Early vsync.** A second vsync fall after 5 of 8 pixels. Expect DONE with `level`=5, and no `sof` entry from the second frame.
- **Arm ignored while capturing.** `arm` during CAPTURE is ignored. `flush` during CAPTURE gives state IDLE, `level`=0 and `out_valid`=0 after one edge.
- **Reset mid-frame.** `reset` during CAPTURE with `level`=3. Next cycle all outputs are at reset values, and subsequent `de` pixels are not pushed.

Source files
------------

// File: rtl/vid_capture_fifo.sv
// Video capture stage: registers the source stream, captures one frame per arm
// request into a first-word-fall-through FIFO, and flags dropped pixels.
module vid_capture_fifo #(
  parameter int DEPTH    = 512,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_r,
  input  logic [7:0]               in_g,
  input  logic [7:0]               in_b,
  input  logic                     in_de,
  input  logic                     in_vsync,
  input  logic                     arm,
  input  logic                     flush,
  input  logic                     pop,
  output logic [7:0]               out_r,
  output logic [7:0]               out_g,
  output logic [7:0]               out_b,
  output logic                     out_sof,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     capturing,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(TOTAL - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Stage S1: registered source signals
  logic [7:0]    r_s1_r;
  logic [7:0]    r_s1_g;
  logic [7:0]    r_s1_b;
  logic          r_s1_de;
  logic          r_s1_vsync;
  logic          r_s1_vsync_prev;

  state_t        r_state;
  logic [CW-1:0] r_pix_cnt;
  logic          r_first;
  logic          r_capturing;
  logic          r_frame_done;
  logic          r_overflow;

  logic [24:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [24:0]   r_head;

  logic          w_vs_fall;
  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [24:0]   w_din;
  logic [AW-1:0] w_rd_ptr_next;
  logic [LW-1:0] w_level_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_r          <= '0;
      r_s1_g          <= '0;
      r_s1_b          <= '0;
      r_s1_de         <= 1'b0;
      r_s1_vsync      <= 1'b1;
      r_s1_vsync_prev <= 1'b1;
    end else begin
      r_s1_r          <= in_r;
      r_s1_g          <= in_g;
      r_s1_b          <= in_b;
      r_s1_de         <= in_de;
      r_s1_vsync      <= in_vsync;
      r_s1_vsync_prev <= r_s1_vsync;
    end
  end

  always_comb begin
    w_vs_fall  = !r_s1_vsync && r_s1_vsync_prev;
    w_empty    = (r_level == '0);
    w_full     = (r_level == FULL_LVL);
    // A vsync fall inside CAPTURE ends the frame; its pixel is not taken.
    w_push_req = !flush && (r_state == ST_CAPTURE) && r_s1_de && !w_vs_fall;
    w_pop      = !flush && pop && !w_empty;
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
    w_din      = {r_first, r_s1_r, r_s1_g, r_s1_b};
    w_rd_ptr_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    w_level_next  = r_level + {{(LW-1){1'b0}}, w_push} - {{(LW-1){1'b0}}, w_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pix_cnt    <= '0;
      r_first      <= 1'b0;
      r_capturing  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (flush) begin
      r_state      <= ST_IDLE;
      r_capturing  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state <= ST_WAIT_VS;
          end
        end
        ST_WAIT_VS: begin
          if (w_vs_fall) begin
            r_state     <= ST_CAPTURE;
            r_capturing <= 1'b1;
            r_pix_cnt   <= '0;
            r_first     <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (w_vs_fall) begin
            r_state      <= ST_DONE;
            r_capturing  <= 1'b0;
            r_frame_done <= 1'b1;
          end else if (r_s1_de) begin
            // Dropped pixels still advance the count so the frame ends on time.
            r_first   <= 1'b0;
            r_pix_cnt <= r_pix_cnt + CW'(1);
            if (r_pix_cnt == LAST_PIX) begin
              r_state      <= ST_DONE;
              r_capturing  <= 1'b0;
              r_frame_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (arm) begin
            r_state      <= ST_WAIT_VS;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_level  <= w_level_next;
      // Head register: bypass the incoming word when it becomes the head,
      // otherwise read ahead from memory. Holds its value when going empty.
      if ((w_push || w_pop) && (w_level_next != '0)) begin
        if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
          r_head <= w_din;
        end else begin
          r_head <= r_mem[w_rd_ptr_next];
        end
      end
    end
  end

  assign out_sof    = r_head[24];
  assign out_r      = r_head[23:16];
  assign out_g      = r_head[15:8];
  assign out_b      = r_head[7:0];
  assign out_valid  = !w_empty;
  assign level      = r_level;
  assign capturing  = r_capturing;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_vid_capture_fifo.sv
// Bench for vid_capture_fifo: a 16-deep and a 4-deep instance share the
// stimulus; each scenario checks one of them against a queue of expected pixels.
module tb_vid_capture_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic       in_de = 1'b0, in_vsync = 1'b1, arm = 1'b0, flush = 1'b0, pop = 1'b0;

  logic [7:0] a_r, a_g, a_b;
  logic       a_sof, a_valid, a_cap, a_done, a_ovf;
  logic [4:0] a_level;
  logic [7:0] b_r, b_g, b_b;
  logic       b_sof, b_valid, b_cap, b_done, b_ovf;
  logic [2:0] b_level;

  logic [24:0] q[$];
  logic [24:0] exp_w;
  int n_vec = 0;
  int n_err = 0;

  vid_capture_fifo #(.DEPTH(16), .H_ACTIVE(4), .V_ACTIVE(2)) dut_a (
    .clk(clk), .reset(reset), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_de(in_de), .in_vsync(in_vsync), .arm(arm), .flush(flush), .pop(pop),
    .out_r(a_r), .out_g(a_g), .out_b(a_b), .out_sof(a_sof), .out_valid(a_valid),
    .level(a_level), .capturing(a_cap), .frame_done(a_done), .overflow(a_ovf)
  );

  vid_capture_fifo #(.DEPTH(4), .H_ACTIVE(4), .V_ACTIVE(2)) dut_b (
    .clk(clk), .reset(reset), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_de(in_de), .in_vsync(in_vsync), .arm(arm), .flush(flush), .pop(pop),
    .out_r(b_r), .out_g(b_g), .out_b(b_b), .out_sof(b_sof), .out_valid(b_valid),
    .level(b_level), .capturing(b_cap), .frame_done(b_done), .overflow(b_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
    q.delete();
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic send_vsync();
    in_vsync = 1'b0; tick(); in_vsync = 1'b1; tick();
  endtask

  task automatic send_pix(input int i, input bit sof, input bit exp_push);
    logic [7:0] v;
    v = 8'(i);
    in_r = v; in_g = v; in_b = v; in_de = 1'b1;
    if (exp_push) q.push_back({sof, v, v, v});
    tick();
  endtask

  task automatic idle();
    in_de = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_vec++;
    if ({a_valid, a_sof, a_cap, a_done, a_ovf, a_level, a_r, a_g, a_b} !== '0) begin
      n_err++;
      $display("FAIL reset_a: got valid=%0b sof=%0b cap=%0b done=%0b ovf=%0b level=%0d rgb=%h%h%h required all 0",
               a_valid, a_sof, a_cap, a_done, a_ovf, a_level, a_r, a_g, a_b);
    end
    n_vec++;
    if ({b_valid, b_cap, b_done, b_ovf, b_level} !== '0) begin
      n_err++;
      $display("FAIL reset_b: got valid=%0b cap=%0b done=%0b ovf=%0b level=%0d required all 0",
               b_valid, b_cap, b_done, b_ovf, b_level);
    end
  endtask

  task automatic test_basic_frame();
    do_flush();
    do_arm();
    in_vsync = 1'b0; tick();
    n_vec++;
    if (a_cap !== 1'b0) begin n_err++; $display("FAIL basic_cap_early: got %0b required 0", a_cap); end
    in_vsync = 1'b1; tick();
    n_vec++;
    if (a_cap !== 1'b1) begin n_err++; $display("FAIL basic_cap_start: got %0b required 1", a_cap); end
    for (int i = 0; i < 8; i++) begin
      send_pix(i, i == 0, 1'b1);
      n_vec++;
      if (a_level !== 5'(i)) begin n_err++; $display("FAIL basic_level%0d: got %0d required %0d", i, a_level, i); end
      if (i == 1) begin
        n_vec++;
        if (a_valid !== 1'b1 || {a_sof, a_r, a_g, a_b} !== 25'h1000000) begin
          n_err++;
          $display("FAIL basic_first_head: got valid=%0b data=%h required valid=1 data=1000000",
                   a_valid, {a_sof, a_r, a_g, a_b});
        end
      end
    end
    n_vec++;
    if (a_done !== 1'b0) begin n_err++; $display("FAIL basic_done_early: got %0b required 0", a_done); end
    idle();
    n_vec++;
    if (a_level !== 5'd8 || a_done !== 1'b1 || a_ovf !== 1'b0 || a_cap !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end: got level=%0d done=%0b ovf=%0b cap=%0b required 8 1 0 0",
               a_level, a_done, a_ovf, a_cap);
    end
    for (int k = 0; k < 16 && q.size() > 0; k++) begin
      exp_w = q.pop_front();
      n_vec++;
      if (a_valid !== 1'b1 || {a_sof, a_r, a_g, a_b} !== exp_w) begin
        n_err++;
        $display("FAIL basic_pop%0d: got valid=%0b data=%h required valid=1 data=%h",
                 k, a_valid, {a_sof, a_r, a_g, a_b}, exp_w);
      end
      pop = 1'b1; tick(); pop = 1'b0;
    end
    n_vec++;
    if (a_valid !== 1'b0 || a_level !== 5'd0) begin
      n_err++;
      $display("FAIL basic_drained: got valid=%0b level=%0d required 0 0", a_valid, a_level);
    end
  endtask

  task automatic test_overflow();
    do_flush();
    do_arm();
    send_vsync();
    for (int i = 0; i < 8; i++) begin
      send_pix(i, i == 0, i < 4);
      if (i == 4) begin
        n_vec++;
        if (b_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_before_full: got %0b required 0", b_ovf); end
      end
      if (i == 5) begin
        n_vec++;
        if (b_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_on_drop: got %0b required 1", b_ovf); end
      end
    end
    idle();
    n_vec++;
    if (b_level !== 3'd4 || b_ovf !== 1'b1 || b_done !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_end: got level=%0d ovf=%0b done=%0b required 4 1 1", b_level, b_ovf, b_done);
    end
    do_arm();
    n_vec++;
    if (b_ovf !== 1'b0 || b_done !== 1'b0 || b_level !== 3'd4) begin
      n_err++;
      $display("FAIL ovf_rearm: got ovf=%0b done=%0b level=%0d required 0 0 4", b_ovf, b_done, b_level);
    end
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      exp_w = q.pop_front();
      n_vec++;
      if (b_valid !== 1'b1 || {b_sof, b_r, b_g, b_b} !== exp_w) begin
        n_err++;
        $display("FAIL ovf_pop%0d: got valid=%0b data=%h required valid=1 data=%h",
                 k, b_valid, {b_sof, b_r, b_g, b_b}, exp_w);
      end
      pop = 1'b1; tick(); pop = 1'b0;
    end
    n_vec++;
    if (b_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got valid=%0b required 0", b_valid); end
  endtask

  task automatic test_full_push_pop();
    do_flush();
    do_arm();
    send_vsync();
    for (int i = 0; i < 5; i++) send_pix(i, i == 0, 1'b1);
    n_vec++;
    if (b_level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d required 4", b_level); end
    exp_w = q.pop_front();
    n_vec++;
    if ({b_sof, b_r, b_g, b_b} !== exp_w) begin
      n_err++;
      $display("FAIL full_head_before: got %h required %h", {b_sof, b_r, b_g, b_b}, exp_w);
    end
    in_de = 1'b0; pop = 1'b1; tick(); pop = 1'b0;
    n_vec++;
    if (b_level !== 3'd4 || b_ovf !== 1'b0 || {b_sof, b_r, b_g, b_b} !== q[0]) begin
      n_err++;
      $display("FAIL full_push_pop: got level=%0d ovf=%0b head=%h required 4 0 %h",
               b_level, b_ovf, {b_sof, b_r, b_g, b_b}, q[0]);
    end
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      exp_w = q.pop_front();
      n_vec++;
      if (b_valid !== 1'b1 || {b_sof, b_r, b_g, b_b} !== exp_w) begin
        n_err++;
        $display("FAIL full_pop%0d: got valid=%0b data=%h required valid=1 data=%h",
                 k, b_valid, {b_sof, b_r, b_g, b_b}, exp_w);
      end
      pop = 1'b1; tick(); pop = 1'b0;
    end
  endtask

  task automatic test_early_vsync();
    do_flush();
    do_arm();
    send_vsync();
    for (int i = 0; i < 5; i++) send_pix(i, i == 0, 1'b1);
    in_de = 1'b0;
    send_vsync();
    n_vec++;
    if (a_done !== 1'b1 || a_cap !== 1'b0) begin
      n_err++;
      $display("FAIL early_state: got done=%0b cap=%0b required 1 0", a_done, a_cap);
    end
    for (int i = 0; i < 3; i++) send_pix(8'h40 + i, 1'b1, 1'b0);
    idle();
    n_vec++;
    if (a_level !== 5'd5 || a_done !== 1'b1) begin
      n_err++;
      $display("FAIL early_level: got level=%0d done=%0b required 5 1", a_level, a_done);
    end
    for (int k = 0; k < 16 && q.size() > 0; k++) begin
      exp_w = q.pop_front();
      n_vec++;
      if (a_valid !== 1'b1 || {a_sof, a_r, a_g, a_b} !== exp_w) begin
        n_err++;
        $display("FAIL early_pop%0d: got valid=%0b data=%h required valid=1 data=%h",
                 k, a_valid, {a_sof, a_r, a_g, a_b}, exp_w);
      end
      pop = 1'b1; tick(); pop = 1'b0;
    end
    n_vec++;
    if (a_valid !== 1'b0) begin n_err++; $display("FAIL early_drained: got valid=%0b required 0", a_valid); end
  endtask

  task automatic test_arm_flush_capture();
    do_flush();
    do_arm();
    send_vsync();
    send_pix(0, 1'b1, 1'b1);
    send_pix(1, 1'b0, 1'b1);
    in_de = 1'b0;
    do_arm();
    n_vec++;
    if (a_cap !== 1'b1 || a_level !== 5'd2) begin
      n_err++;
      $display("FAIL arm_ignored: got cap=%0b level=%0d required 1 2", a_cap, a_level);
    end
    send_pix(2, 1'b0, 1'b1);
    idle();
    n_vec++;
    if (a_level !== 5'd3) begin n_err++; $display("FAIL arm_still_capturing: got level=%0d required 3", a_level); end
    flush = 1'b1; tick(); flush = 1'b0;
    q.delete();
    n_vec++;
    if (a_cap !== 1'b0 || a_level !== 5'd0 || a_valid !== 1'b0 || a_done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_capture: got cap=%0b level=%0d valid=%0b done=%0b required 0 0 0 0",
               a_cap, a_level, a_valid, a_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_flush();
    do_arm();
    send_vsync();
    for (int i = 0; i < 3; i++) send_pix(i + 9, i == 0, 1'b1);
    idle();
    n_vec++;
    if (a_level !== 5'd3 || a_sof !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: got level=%0d sof=%0b required 3 1", a_level, a_sof);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    q.delete();
    n_vec++;
    if ({a_valid, a_sof, a_cap, a_done, a_ovf, a_level, a_r, a_g, a_b} !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got valid=%0b sof=%0b cap=%0b done=%0b ovf=%0b level=%0d rgb=%h%h%h required all 0",
               a_valid, a_sof, a_cap, a_done, a_ovf, a_level, a_r, a_g, a_b);
    end
    for (int i = 0; i < 3; i++) send_pix(i + 20, 1'b0, 1'b0);
    idle();
    idle();
    n_vec++;
    if (a_level !== 5'd0 || a_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_no_push: got level=%0d valid=%0b required 0 0", a_level, a_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_full_push_pop();
    test_early_vsync();
    test_arm_flush_capture();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
